// File: rtl/reset_pkg.sv
// reset_pkg: shared state codes and elaboration helpers for the reset sequencer.
//   state_e : FSM state encoding, also the code map driven on o_state
//   max3    : largest of three values, used to size the shared counter
package reset_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous status bit.
//   i_clk   : destination clock
//   i_arstn : asynchronous active-low reset, clears both flops
//   i_d     : asynchronous input bit
//   o_q     : synchronized output, two clocks of latency
module sync_2ff (
    input  logic i_clk,
    input  logic i_arstn,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds reset, waits for clock lock, then releases reset domains one by one.
//   i_clk    : single clock, all logic in this domain
//   i_arstn  : asynchronous active-low reset
//   i_locked : asynchronous PLL/clock-ready status, active-high
//   i_sw_rst : synchronous level-sensitive software reset request
//   o_rst_n  : per-stage active-low resets, bit 0 released first
//   o_done   : every stage released, system running
//   o_fault  : lock did not arrive within LOCK_TIMEOUT clocks
//   o_state  : current FSM state code (see reset_pkg::state_e)
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int NUM_STAGE    = 4,
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_DELAY  = 32,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                 i_clk,
    input  logic                 i_arstn,
    input  logic                 i_locked,
    input  logic                 i_sw_rst,
    output logic [NUM_STAGE-1:0] o_rst_n,
    output logic                 o_done,
    output logic                 o_fault,
    output logic [2:0]           o_state
);

    localparam int CW = $clog2(max3(HOLD_CYCLES, STAGE_DELAY, LOCK_TIMEOUT) + 1);
    localparam int IW = $clog2(NUM_STAGE + 1);

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [IW-1:0] ALL_STAGES = IW'(NUM_STAGE);

    logic lock_s;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [NUM_STAGE-1:0] rst_q, rst_d;
    logic                 done_q, done_d;
    logic                 fault_q, fault_d;
    logic                 abort;

    sync_2ff u_lock_sync (
        .i_clk   (i_clk),
        .i_arstn (i_arstn),
        .i_d     (i_locked),
        .o_q     (lock_s)
    );

    // Return to HOLD: software request from any post-hold state, lock loss only
    // once release has started (in WAIT_LOCK a missing lock feeds the timeout).
    assign abort = (i_sw_rst && state_q != ST_HOLD) ||
                   (!lock_s && (state_q == ST_RELEASE || state_q == ST_RUN));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        case (state_q)
            ST_HOLD: begin
                idx_d = '0;
                if (i_sw_rst) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = IW'(1);
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_FAULT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == STAGE_LAST) begin
                    cnt_d = '0;
                    if (idx_q == ALL_STAGES) state_d = ST_RUN;
                    else idx_d = idx_q + IW'(1);
                end
            end
            ST_RUN:   cnt_d = '0;
            ST_FAULT: cnt_d = '0;
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
        if (abort) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
        end
        // Stage k is out of reset once idx has passed it; idx only grows in RELEASE.
        for (int i = 0; i < NUM_STAGE; i++) begin
            rst_d[i] = (state_d == ST_RELEASE || state_d == ST_RUN) && (i < int'(idx_d));
        end
        done_d  = (state_d == ST_RUN);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign o_rst_n = rst_q;
    assign o_done  = done_q;
    assign o_fault = fault_q;
    assign o_state = state_q;

endmodule
